// File: rtl/rocc_cmd_arbiter.sv
// rocc_cmd_arbiter: round-robin sharing of one RoCC command/response port
// among NUM_REQ requesters. Responses to xd=1 commands are routed back
// through an in-order FIFO of requester ids.
module rocc_cmd_arbiter #(
  parameter int xLen      = 64,
  parameter int NUM_REQ   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_cmd_valid,
  output logic [NUM_REQ-1:0]      req_cmd_ready,
  input  logic [NUM_REQ*7-1:0]    req_cmd_funct,
  input  logic [NUM_REQ*5-1:0]    req_cmd_rd,
  input  logic [NUM_REQ-1:0]      req_cmd_xd,
  input  logic [NUM_REQ*xLen-1:0] req_cmd_rs1,
  input  logic [NUM_REQ*xLen-1:0] req_cmd_rs2,
  output logic                    acc_cmd_valid,
  input  logic                    acc_cmd_ready,
  output logic [6:0]              acc_cmd_funct,
  output logic [4:0]              acc_cmd_rd,
  output logic                    acc_cmd_xd,
  output logic [xLen-1:0]         acc_cmd_rs1,
  output logic [xLen-1:0]         acc_cmd_rs2,
  input  logic                    acc_resp_valid,
  output logic                    acc_resp_ready,
  input  logic [4:0]              acc_resp_rd,
  input  logic [xLen-1:0]         acc_resp_data,
  output logic [NUM_REQ-1:0]      req_resp_valid,
  input  logic [NUM_REQ-1:0]      req_resp_ready,
  output logic [4:0]              req_resp_rd,
  output logic [xLen-1:0]         req_resp_data,
  output logic                    busy,
  output logic                    err_unexp_resp
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           err_q, err_d;
  logic [IDW-1:0] fifo_q [MAX_OUTST];
  logic [IDW-1:0] fifo_d [MAX_OUTST];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [NUM_REQ-1:0] eligible;
  logic [IDW-1:0]     grant;
  logic               gnt_vld;
  logic               cmd_fire;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IDW-1:0]     head;

  assign fifo_full  = (count_q == CW'(MAX_OUTST));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Eligibility uses the registered count, so a same-cycle pop never unblocks an xd push.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_cmd_valid[i] && !(req_cmd_xd[i] && fifo_full);
  end

  // Grant selection: held grantee while locked, else first eligible from rr_ptr with wrap.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    if (lock_q) begin
      grant   = lock_id_q;
      gnt_vld = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_vld && eligible[idx]) begin
          gnt_vld = 1'b1;
          grant   = IDW'(idx);
        end
      end
    end
  end

  // Command mux toward the accelerator; fields are zero when nobody is granted.
  always_comb begin
    acc_cmd_valid = gnt_vld;
    acc_cmd_funct = '0;
    acc_cmd_rd    = '0;
    acc_cmd_xd    = 1'b0;
    acc_cmd_rs1   = '0;
    acc_cmd_rs2   = '0;
    req_cmd_ready = '0;
    if (gnt_vld) begin
      acc_cmd_funct = req_cmd_funct[int'(grant)*7 +: 7];
      acc_cmd_rd    = req_cmd_rd[int'(grant)*5 +: 5];
      acc_cmd_xd    = req_cmd_xd[grant];
      acc_cmd_rs1   = req_cmd_rs1[int'(grant)*xLen +: xLen];
      acc_cmd_rs2   = req_cmd_rs2[int'(grant)*xLen +: xLen];
      req_cmd_ready[grant] = acc_cmd_ready;
    end
  end

  assign cmd_fire = gnt_vld && acc_cmd_ready;
  assign push     = cmd_fire && acc_cmd_xd;

  // Response routing: head id selects the target; with an empty FIFO responses are swallowed.
  always_comb begin
    req_resp_valid = '0;
    acc_resp_ready = 1'b1;
    if (!fifo_empty) begin
      req_resp_valid[head] = acc_resp_valid;
      acc_resp_ready       = req_resp_ready[head];
    end
  end

  assign pop            = !fifo_empty && acc_resp_valid && acc_resp_ready;
  assign req_resp_rd    = acc_resp_rd;
  assign req_resp_data  = acc_resp_data;
  assign busy           = !fifo_empty || gnt_vld;
  assign err_unexp_resp = err_q;

  // Next-state for arbiter pointer, lock, id FIFO and error flag.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = gnt_vld && !acc_cmd_ready;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q | (fifo_empty && acc_resp_valid);
    if (lock_d) lock_id_d = grant;
    if (cmd_fire)
      rr_ptr_d = (int'(grant) == NUM_REQ - 1) ? '0 : IDW'(int'(grant) + 1);
    if (push) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // Id storage needs no reset; entries are only read once count says they are valid.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Directed table-driven bench for rocc_cmd_arbiter (NUM_REQ=2, MAX_OUTST=4).
module tb_rocc_cmd_arbiter;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       req_cmd_valid, req_cmd_ready, req_cmd_xd;
  logic [13:0]      req_cmd_funct;
  logic [9:0]       req_cmd_rd;
  logic [127:0]     req_cmd_rs1, req_cmd_rs2;
  logic             acc_cmd_valid, acc_cmd_ready, acc_cmd_xd;
  logic [6:0]       acc_cmd_funct;
  logic [4:0]       acc_cmd_rd;
  logic [63:0]      acc_cmd_rs1, acc_cmd_rs2;
  logic             acc_resp_valid, acc_resp_ready;
  logic [4:0]       acc_resp_rd, req_resp_rd;
  logic [63:0]      acc_resp_data, req_resp_data;
  logic [1:0]       req_resp_valid, req_resp_ready;
  logic             busy, err_unexp_resp;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rocc_cmd_arbiter dut (
    .clock(clock), .reset(reset),
    .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
    .req_cmd_funct(req_cmd_funct), .req_cmd_rd(req_cmd_rd), .req_cmd_xd(req_cmd_xd),
    .req_cmd_rs1(req_cmd_rs1), .req_cmd_rs2(req_cmd_rs2),
    .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
    .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rd(acc_cmd_rd), .acc_cmd_xd(acc_cmd_xd),
    .acc_cmd_rs1(acc_cmd_rs1), .acc_cmd_rs2(acc_cmd_rs2),
    .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
    .acc_resp_rd(acc_resp_rd), .acc_resp_data(acc_resp_data),
    .req_resp_valid(req_resp_valid), .req_resp_ready(req_resp_ready),
    .req_resp_rd(req_resp_rd), .req_resp_data(req_resp_data),
    .busy(busy), .err_unexp_resp(err_unexp_resp)
  );

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  xd;
    logic        ar;
    logic        rv;
    logic [1:0]  rr;
    logic [63:0] rdata;
    int          gnt;    // expected grantee, -1 = none
    logic [1:0]  crdy;
    logic [1:0]  rspv;
    logic        arr;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] xd, logic ar, logic rv,
                              logic [1:0] rr, logic [63:0] rdata, int gnt,
                              logic [1:0] crdy, logic [1:0] rspv, logic arr,
                              logic bsy, logic err);
    vec_t t;
    t.v = v; t.xd = xd; t.ar = ar; t.rv = rv; t.rr = rr; t.rdata = rdata;
    t.gnt = gnt; t.crdy = crdy; t.rspv = rspv; t.arr = arr; t.bsy = bsy; t.err = err;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, check outputs before the next posedge.
  task automatic apply(input vec_t t, input string tag);
    logic [6:0]  e_funct;
    logic [63:0] e_rs1;
    logic        e_xd;
    @(negedge clock);
    req_cmd_valid  = t.v;
    req_cmd_xd     = t.xd;
    acc_cmd_ready  = t.ar;
    acc_resp_valid = t.rv;
    req_resp_ready = t.rr;
    acc_resp_data  = t.rdata;
    #1;
    e_funct = 7'h00; e_rs1 = 64'h0; e_xd = 1'b0;
    if (t.gnt == 0) begin e_funct = 7'h10; e_rs1 = 64'hA0; e_xd = t.xd[0]; end
    if (t.gnt == 1) begin e_funct = 7'h21; e_rs1 = 64'hA1; e_xd = t.xd[1]; end
    chk({tag, ".acc_cmd_valid"}, 64'(acc_cmd_valid), 64'(t.gnt >= 0));
    chk({tag, ".acc_cmd_funct"}, 64'(acc_cmd_funct), 64'(e_funct));
    chk({tag, ".acc_cmd_rs1"}, acc_cmd_rs1, e_rs1);
    chk({tag, ".acc_cmd_xd"}, 64'(acc_cmd_xd), 64'(e_xd));
    chk({tag, ".req_cmd_ready"}, 64'(req_cmd_ready), 64'(t.crdy));
    chk({tag, ".req_resp_valid"}, 64'(req_resp_valid), 64'(t.rspv));
    chk({tag, ".acc_resp_ready"}, 64'(acc_resp_ready), 64'(t.arr));
    chk({tag, ".busy"}, 64'(busy), 64'(t.bsy));
    chk({tag, ".err"}, 64'(err_unexp_resp), 64'(t.err));
    if (t.rv) begin
      chk({tag, ".resp_data"}, req_resp_data, t.rdata);
      chk({tag, ".resp_rd"}, 64'(req_resp_rd), 64'd7);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    req_cmd_valid = '0; req_cmd_xd = '0; acc_cmd_ready = 1'b0;
    acc_resp_valid = 1'b0; req_resp_ready = '0; acc_resp_data = '0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk({tag, ".acc_cmd_valid"}, 64'(acc_cmd_valid), 64'd0);
    chk({tag, ".req_cmd_ready"}, 64'(req_cmd_ready), 64'd0);
    chk({tag, ".req_resp_valid"}, 64'(req_resp_valid), 64'd0);
    chk({tag, ".acc_resp_ready"}, 64'(acc_resp_ready), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".err"}, 64'(err_unexp_resp), 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    req_cmd_funct  = {7'h21, 7'h10};
    req_cmd_rd     = {5'd2, 5'd1};
    req_cmd_rs1    = {64'hA1, 64'hA0};
    req_cmd_rs2    = {64'hB1, 64'hB0};
    acc_resp_rd    = 5'd7;
    req_cmd_valid  = '0; req_cmd_xd = '0; acc_cmd_ready = 1'b0;
    acc_resp_valid = 1'b0; req_resp_ready = '0; acc_resp_data = '0;

    //        v      xd     ar rv rr     data    gnt crdy   rspv   arr bsy err
    // Round robin, both valid, xd=0.
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b00, 64'h0,  0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b00, 64'h0,  1, 2'b10, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b00, 64'h0,  0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b00, 64'h0,  1, 2'b10, 2'b00, 1, 1, 0));
    // rr_ptr back at 0: stalled grant goes to 0, then completes.
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 2'b00, 64'h0,  0, 2'b00, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b00, 64'h0,  0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b10, 2'b00, 1, 0, 2'b00, 64'h0,  1, 2'b10, 2'b00, 1, 1, 0));
    // Lock: req1 stalled 3 cycles, req0 joins, grant stays 1.
    tbl.push_back(mk(2'b10, 2'b00, 0, 0, 2'b00, 64'h0,  1, 2'b00, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b10, 2'b00, 0, 0, 2'b00, 64'h0,  1, 2'b00, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 2'b00, 64'h0,  1, 2'b00, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b00, 64'h0,  1, 2'b10, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b00, 64'h0,  0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 2'b00, 64'h0, -1, 2'b00, 2'b00, 1, 0, 0));
    // xd=1 from req0, req1, req0, then in-order responses.
    tbl.push_back(mk(2'b01, 2'b01, 1, 0, 2'b11, 64'h0,  0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b10, 2'b10, 1, 0, 2'b11, 64'h0,  1, 2'b10, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b01, 2'b01, 1, 0, 2'b11, 64'h0,  0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 64'h11, -1, 2'b00, 2'b01, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 64'h22, -1, 2'b00, 2'b10, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 64'h33, -1, 2'b00, 2'b01, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 2'b11, 64'h0, -1, 2'b00, 2'b00, 1, 0, 0));
    // Unexpected response with empty FIFO: dropped, sticky error.
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b00, 64'h99, -1, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 2'b00, 64'h0, -1, 2'b00, 2'b00, 1, 0, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 2'b00, 64'h0, -1, 2'b00, 2'b00, 1, 0, 1));

    do_reset("rst");
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("t%0d", i));

    // FIFO full: four xd=1 from req0, then req0 xd=1 skipped while req1 xd=0 proceeds.
    for (int i = 0; i < 4; i++)
      apply(mk(2'b01, 2'b01, 1, 0, 2'b11, 64'h0, 0, 2'b01, 2'b00, 1, 1, 1), $sformatf("fill%0d", i));
    apply(mk(2'b11, 2'b01, 1, 0, 2'b11, 64'h0,  1, 2'b10, 2'b00, 1, 1, 1), "full_skip");
    apply(mk(2'b01, 2'b01, 1, 1, 2'b11, 64'h44, -1, 2'b00, 2'b01, 1, 1, 1), "full_pop");
    apply(mk(2'b01, 2'b01, 1, 0, 2'b11, 64'h0,  0, 2'b01, 2'b00, 1, 1, 1), "full_accept");

    // Head requester not ready: no pop for 2 cycles, then 4 pops drain the FIFO.
    apply(mk(2'b00, 2'b00, 1, 1, 2'b10, 64'h55, -1, 2'b00, 2'b01, 0, 1, 1), "stall0");
    apply(mk(2'b00, 2'b00, 1, 1, 2'b10, 64'h55, -1, 2'b00, 2'b01, 0, 1, 1), "stall1");
    for (int i = 0; i < 4; i++)
      apply(mk(2'b00, 2'b00, 1, 1, 2'b11, 64'h60 + 64'(i), -1, 2'b00, 2'b01, 1, 1, 1), $sformatf("drain%0d", i));
    apply(mk(2'b00, 2'b00, 1, 0, 2'b00, 64'h0, -1, 2'b00, 2'b00, 1, 0, 1), "drained");

    // Reset with an outstanding xd command: FIFO and flag cleared, late response unexpected.
    apply(mk(2'b10, 2'b10, 1, 0, 2'b11, 64'h0,  1, 2'b10, 2'b00, 1, 1, 1), "pre_rst");
    do_reset("mid_rst");
    apply(mk(2'b00, 2'b00, 1, 1, 2'b11, 64'h66, -1, 2'b00, 2'b00, 1, 0, 0), "late_resp");
    apply(mk(2'b00, 2'b00, 1, 0, 2'b00, 64'h0, -1, 2'b00, 2'b00, 1, 0, 1), "late_err");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
